// File: rtl/fetch_pc_unit_pkg.sv
// Shared fetch/decode definitions: FSM state encoding, instruction field
// positions and the default reset PC.
package mips_pkg;

    typedef enum logic [2:0] {
        RST_IDLE = 3'd0,
        REQ      = 3'd1,
        WAIT     = 3'd2,
        HOLD     = 3'd3,
        FAULT    = 3'd4
    } fetch_state_e;

    localparam int OP_HI  = 31;
    localparam int OP_LO  = 26;
    localparam int RT_HI  = 20;
    localparam int RT_LO  = 16;
    localparam int IMM_HI = 15;
    localparam int IMM_LO = 0;
    localparam int TGT_HI = 25;
    localparam int TGT_LO = 0;

    localparam logic [31:0] RESET_PC_DEFAULT = 32'h0000_0000;

endpackage

// File: rtl/fetch_pc_unit_if.sv
// Instruction-memory request/ready bus between the fetch stage (master)
// and the instruction memory (slave).
interface fetch_pc_unit_if #(
    parameter int ADDR_W = 32
);
    logic              imem_req;
    logic [ADDR_W-1:0] imem_addr;
    logic [31:0]       imem_rdata;
    logic              imem_ready;

    modport master (
        output imem_req,
        output imem_addr,
        input  imem_rdata,
        input  imem_ready
    );

    modport slave (
        input  imem_req,
        input  imem_addr,
        output imem_rdata,
        output imem_ready
    );
endinterface

// File: rtl/fetch_pc_unit_next_pc_sel.sv
// Combinational next-PC selection: jr > jump > taken branch > pc+4.
// Only the low 26 instruction bits are needed (jump index and immediate).
module next_pc_sel
    import mips_pkg::*;
#(
    parameter int ADDR_W = 32
) (
    input  logic [ADDR_W-1:0] pc,
    input  logic [25:0]       instr_tgt,
    input  logic              jump,
    input  logic              jreg,
    input  logic              branch,
    input  logic              branchne,
    input  logic              branchgtz,
    input  logic              branchgez,
    input  logic              branchltz,
    input  logic              alu_zero,
    input  logic [31:0]       rs_data,
    output logic [ADDR_W-1:0] next_pc,
    output logic              taken
);

    logic [ADDR_W-1:0] pc4_s;
    logic [ADDR_W-1:0] br_target_s;
    logic [ADDR_W-1:0] j_target_s;
    logic [15:0]       imm_s;
    logic              br_taken_s;

    assign imm_s       = instr_tgt[IMM_HI:IMM_LO];
    assign pc4_s       = pc + ADDR_W'(32'd4);
    assign br_target_s = pc4_s + {{(ADDR_W-18){imm_s[15]}}, imm_s, 2'b00};
    assign j_target_s  = {pc4_s[ADDR_W-1:28], instr_tgt[TGT_HI:TGT_LO], 2'b00};

    // Any asserted strobe whose condition holds redirects to the branch target.
    always_comb begin
        br_taken_s = (branch    &  alu_zero)
                   | (branchne  & ~alu_zero)
                   | (branchgtz & ~rs_data[31] & (|rs_data))
                   | (branchgez & ~rs_data[31])
                   | (branchltz &  rs_data[31]);
    end

    // Priority select of the redirect target.
    always_comb begin
        next_pc = pc4_s;
        taken   = 1'b0;
        if (jreg) begin
            next_pc = rs_data[ADDR_W-1:0];
            taken   = 1'b1;
        end else if (jump) begin
            next_pc = j_target_s;
            taken   = 1'b1;
        end else if (br_taken_s) begin
            next_pc = br_target_s;
            taken   = 1'b1;
        end else begin
            next_pc = pc4_s;
            taken   = 1'b0;
        end
    end

endmodule

// File: rtl/fetch_pc_unit.sv
// Instruction fetch and next-PC stage. Optional FETCH_MISALIGN_CHECK_EN adds
// misalign_err and a sticky FAULT state on a misaligned jr target.
module fetch_pc_unit
    import mips_pkg::*;
#(
    parameter logic [31:0] RESET_PC = RESET_PC_DEFAULT,
    parameter int          ADDR_W   = 32
) (
    input  logic              clk,
    input  logic              rst,
    fetch_pc_unit_if.master   imem,
    output logic [31:0]       instr,
    output logic              instr_valid,
    input  logic              stall,
    input  logic              jump,
    input  logic              jreg,
    input  logic              branch,
    input  logic              branchne,
    input  logic              branchgtz,
    input  logic              branchgez,
    input  logic              branchltz,
    input  logic              alu_zero,
    input  logic [31:0]       rs_data,
    output logic [ADDR_W-1:0] pc,
    output logic [ADDR_W-1:0] link_addr
`ifdef FETCH_MISALIGN_CHECK_EN
    ,
    output logic              misalign_err
`endif
);

    fetch_state_e      state_r;
    logic [ADDR_W-1:0] pc_r;
    logic [31:0]       instr_r;
    logic              valid_r;
    logic              req_r;
    logic              commit_s;
    logic [ADDR_W-1:0] next_pc_s;
    logic              taken_s;
    logic [ADDR_W-1:0] pc_sel_s;
    logic [ADDR_W-1:0] pc_load_s;

`ifdef FETCH_MISALIGN_CHECK_EN
    logic err_r;
    logic misalign_s;
    assign misalign_s   = |pc_load_s[1:0];
    assign misalign_err = err_r;
`else
    localparam logic [ADDR_W-1:0] ALIGN_MASK = {{(ADDR_W-2){1'b1}}, 2'b00};
`endif

    assign commit_s       = valid_r & ~stall;
    assign link_addr      = pc_r + ADDR_W'(32'd4);
    assign pc             = pc_r;
    assign instr          = instr_r;
    assign instr_valid    = valid_r;
    assign imem.imem_req  = req_r;
    assign imem.imem_addr = pc_r;

    next_pc_sel #(
        .ADDR_W (ADDR_W)
    ) u_next_pc_sel (
        .pc        (pc_r),
        .instr_tgt (instr_r[TGT_HI:TGT_LO]),
        .jump      (jump),
        .jreg      (jreg),
        .branch    (branch),
        .branchne  (branchne),
        .branchgtz (branchgtz),
        .branchgez (branchgez),
        .branchltz (branchltz),
        .alu_zero  (alu_zero),
        .rs_data   (rs_data),
        .next_pc   (next_pc_s),
        .taken     (taken_s)
    );

    // Fall back to the sequential address when nothing redirects.
    always_comb begin
        pc_sel_s = link_addr;
        if (taken_s) begin
            pc_sel_s = next_pc_s;
        end else begin
            pc_sel_s = link_addr;
        end
`ifdef FETCH_MISALIGN_CHECK_EN
        pc_load_s = pc_sel_s;
`else
        pc_load_s = pc_sel_s & ALIGN_MASK;
`endif
    end

    // Fetch FSM with registered request, instruction, valid and PC.
    // The async reset clears imem_req immediately, aborting any open fetch.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_r <= RST_IDLE;
            pc_r    <= RESET_PC[ADDR_W-1:0];
            instr_r <= 32'h0000_0000;
            valid_r <= 1'b0;
            req_r   <= 1'b0;
`ifdef FETCH_MISALIGN_CHECK_EN
            err_r   <= 1'b0;
`endif
        end else begin
            case (state_r)
                RST_IDLE: begin
                    req_r   <= 1'b1;
                    state_r <= REQ;
                end
                REQ, WAIT: begin
                    if (imem.imem_ready) begin
                        instr_r <= imem.imem_rdata;
                        valid_r <= 1'b1;
                        req_r   <= 1'b0;
                        state_r <= HOLD;
                    end else begin
                        state_r <= WAIT;
                    end
                end
                HOLD: begin
                    if (commit_s) begin
                        pc_r    <= pc_load_s;
                        valid_r <= 1'b0;
`ifdef FETCH_MISALIGN_CHECK_EN
                        if (misalign_s) begin
                            err_r   <= 1'b1;
                            req_r   <= 1'b0;
                            state_r <= FAULT;
                        end else begin
                            req_r   <= 1'b1;
                            state_r <= REQ;
                        end
`else
                        req_r   <= 1'b1;
                        state_r <= REQ;
`endif
                    end
                end
                FAULT: begin
                    req_r   <= 1'b0;
                    valid_r <= 1'b0;
                    state_r <= FAULT;
                end
                default: begin
                    req_r   <= 1'b0;
                    valid_r <= 1'b0;
                    state_r <= RST_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_fetch_pc_unit.sv
// Self-checking bench for fetch_pc_unit: directed scenarios plus randomized
// fetch/redirect sequences checked against an arithmetic next-PC model.
module tb_fetch_pc_unit;

    localparam logic [6:0] C_NONE = 7'b0000000;
    localparam logic [6:0] C_JREG = 7'b1000000;
    localparam logic [6:0] C_JUMP = 7'b0100000;
    localparam logic [6:0] C_BEQ  = 7'b0010000;
    localparam logic [6:0] C_BNE  = 7'b0001000;
    localparam logic [6:0] C_BGTZ = 7'b0000100;
    localparam logic [6:0] C_BGEZ = 7'b0000010;
    localparam logic [6:0] C_BLTZ = 7'b0000001;

    localparam logic [31:0] W_ADD  = 32'h0022_1820;
    localparam logic [31:0] W_BEQ  = 32'h1022_FFFF;
    localparam logic [31:0] W_BGTZ = 32'h1C20_0004;
    localparam logic [31:0] W_BGEZ = 32'h0421_0004;
    localparam logic [31:0] W_BLTZ = 32'h0420_0004;
    localparam logic [31:0] W_JAL  = 32'h0C00_0010;

    logic        clk = 1'b0;
    logic        rst;
    logic [31:0] instr;
    logic        instr_valid;
    logic        stall;
    logic        jump, jreg, branch, branchne, branchgtz, branchgez, branchltz;
    logic        alu_zero;
    logic [31:0] rs_data;
    logic [31:0] pc;
    logic [31:0] link_addr;
    logic [6:0]  ctl;
`ifdef FETCH_MISALIGN_CHECK_EN
    logic        misalign_err;
`endif

    int          vectors = 0;
    int          errors  = 0;
    logic [31:0] exp_pc;

    always #5 clk = ~clk;

    assign {jreg, jump, branch, branchne, branchgtz, branchgez, branchltz} = ctl;

    fetch_pc_unit_if #(.ADDR_W(32)) bus ();

    fetch_pc_unit #(
        .RESET_PC (32'h0000_0000),
        .ADDR_W   (32)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .imem        (bus),
        .instr       (instr),
        .instr_valid (instr_valid),
        .stall       (stall),
        .jump        (jump),
        .jreg        (jreg),
        .branch      (branch),
        .branchne    (branchne),
        .branchgtz   (branchgtz),
        .branchgez   (branchgez),
        .branchltz   (branchltz),
        .alu_zero    (alu_zero),
        .rs_data     (rs_data),
        .pc          (pc),
        .link_addr   (link_addr)
`ifdef FETCH_MISALIGN_CHECK_EN
        ,
        .misalign_err(misalign_err)
`endif
    );

    // Reference next PC from the architectural rules, using plain arithmetic.
    function automatic logic [31:0] model_next(input logic [31:0] cur, input logic [31:0] ins,
                                               input logic [6:0] c, input logic az,
                                               input logic [31:0] rs);
        logic [31:0] seq;
        int          off;
        bit          tk;
        seq = cur + 32'd4;
        off = int'($signed(ins[15:0])) * 4;
        tk  = (c[4] && az) || (c[3] && !az) || (c[2] && $signed(rs) > 0) ||
              (c[1] && $signed(rs) >= 0) || (c[0] && $signed(rs) < 0);
        if (c[6]) return rs & 32'hFFFF_FFFC;
        if (c[5]) return (seq & 32'hF000_0000) | ((ins & 32'h03FF_FFFF) << 2);
        if (tk) return seq + off;
        return seq;
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Wait for a request, hold off ready for 'delay' cycles, then return 'word'.
    task automatic serve(input logic [31:0] word, input int delay, output int req_cnt,
                         output bit stable, output logic [31:0] addr0, output bit ok);
        int n;
        ok = 1'b1; req_cnt = 0; stable = 1'b1; addr0 = 32'h0; n = 0;
        while (bus.imem_req !== 1'b1 && n < 20) begin
            tick();
            n++;
        end
        if (bus.imem_req !== 1'b1) begin
            ok = 1'b0;
            return;
        end
        addr0 = bus.imem_addr;
        for (int i = 0; i < delay; i++) begin
            if (bus.imem_req === 1'b1) req_cnt++;
            if (bus.imem_addr !== addr0) stable = 1'b0;
            bus.imem_ready = 1'b0;
            bus.imem_rdata = $urandom;
            tick();
        end
        if (bus.imem_req === 1'b1) req_cnt++;
        if (bus.imem_addr !== addr0) stable = 1'b0;
        bus.imem_ready = 1'b1;
        bus.imem_rdata = word;
        tick();
        bus.imem_ready = 1'b0;
        bus.imem_rdata = $urandom;
    endtask

    task automatic commit(input logic [6:0] c, input logic az, input logic [31:0] rs);
        ctl = c; alu_zero = az; rs_data = rs; stall = 1'b0;
        tick();
        ctl = C_NONE;
    endtask

    task automatic goto_pc(input logic [31:0] target);
        int rc; bit st, ok; logic [31:0] a;
        serve(W_ADD, 0, rc, st, a, ok);
        commit(C_JREG, 1'b0, target);
        exp_pc = target;
    endtask

    task automatic test_reset();
        rst = 1'b0; stall = 1'b0; ctl = C_NONE; alu_zero = 1'b0; rs_data = 32'h0;
        bus.imem_ready = 1'b0; bus.imem_rdata = 32'h0;
        #2 rst = 1'b1;
        tick(); tick();
        vectors++; if (pc !== 32'h0) begin errors++; $display("FAIL reset_pc got %h want %h", pc, 32'h0); end
        vectors++; if (bus.imem_req !== 1'b0) begin errors++; $display("FAIL reset_req got %b want 0", bus.imem_req); end
        vectors++; if (instr_valid !== 1'b0) begin errors++; $display("FAIL reset_valid got %b want 0", instr_valid); end
        vectors++; if (instr !== 32'h0) begin errors++; $display("FAIL reset_instr got %h want 0", instr); end
        rst = 1'b0;
        tick();
        vectors++; if (bus.imem_req !== 1'b1 || bus.imem_addr !== 32'h0) begin
            errors++; $display("FAIL first_req got req=%b addr=%h want 1/0", bus.imem_req, bus.imem_addr);
        end
        exp_pc = 32'h0;
    endtask

    task automatic test_sequential();
        int rc; bit st, ok; logic [31:0] a;
        for (int k = 0; k < 2; k++) begin
            serve(W_ADD, 0, rc, st, a, ok);
            vectors++; if (!ok || a !== exp_pc || rc != 1) begin
                errors++; $display("FAIL seq_fetch got ok=%0d addr=%h cnt=%0d want addr=%h cnt=1", ok, a, rc, exp_pc);
            end
            vectors++; if (instr_valid !== 1'b1 || instr !== W_ADD || bus.imem_req !== 1'b0) begin
                errors++; $display("FAIL seq_hold got v=%b instr=%h req=%b", instr_valid, instr, bus.imem_req);
            end
            commit(C_NONE, 1'b0, 32'h0);
            exp_pc = exp_pc + 32'd4;
            vectors++; if (pc !== exp_pc || instr_valid !== 1'b0 || bus.imem_req !== 1'b1) begin
                errors++; $display("FAIL seq_commit got pc=%h v=%b req=%b want pc=%h", pc, instr_valid, bus.imem_req, exp_pc);
            end
        end
        vectors++; if (pc !== 32'h8) begin errors++; $display("FAIL seq_pc8 got %h want 00000008", pc); end
    endtask

    task automatic test_wait_latency();
        int rc; bit st, ok; logic [31:0] a;
        serve(W_ADD, 3, rc, st, a, ok);
        vectors++; if (!ok || rc != 4 || !st || a !== 32'h8) begin
            errors++; $display("FAIL wait_req got ok=%0d cnt=%0d stable=%0d addr=%h want cnt=4 addr=8", ok, rc, st, a);
        end
        vectors++; if (instr_valid !== 1'b1) begin errors++; $display("FAIL wait_valid got %b want 1", instr_valid); end
        commit(C_NONE, 1'b0, 32'h0);
        exp_pc = 32'hC;
        vectors++; if (pc !== 32'hC) begin errors++; $display("FAIL wait_pc got %h want 0000000c", pc); end
    endtask

    task automatic test_beq();
        int rc; bit st, ok; logic [31:0] a;
        goto_pc(32'h10);
        serve(W_BEQ, 0, rc, st, a, ok);
        commit(C_BEQ, 1'b1, 32'h0);
        vectors++; if (pc !== 32'h10) begin errors++; $display("FAIL beq_taken got %h want 00000010", pc); end
        serve(W_BEQ, 1, rc, st, a, ok);
        commit(C_BEQ, 1'b0, 32'h0);
        vectors++; if (pc !== 32'h14) begin errors++; $display("FAIL beq_not_taken got %h want 00000014", pc); end
        exp_pc = 32'h14;
    endtask

    task automatic test_sign_branches();
        int rc; bit st, ok; logic [31:0] a;
        logic [6:0]  kinds [3] = '{C_BGTZ, C_BGEZ, C_BLTZ};
        logic [31:0] words [3] = '{W_BGTZ, W_BGEZ, W_BLTZ};
        logic [31:0] vals  [3] = '{32'h0, 32'h1, 32'h8000_0000};
        logic [31:0] want  [9] = '{32'h24, 32'h34, 32'h24,
                                   32'h34, 32'h34, 32'h24,
                                   32'h24, 32'h24, 32'h34};
        for (int k = 0; k < 3; k++) begin
            for (int v = 0; v < 3; v++) begin
                goto_pc(32'h20);
                serve(words[k], 0, rc, st, a, ok);
                vectors++; if (link_addr !== 32'h24) begin
                    errors++; $display("FAIL sign_link got %h want 00000024", link_addr);
                end
                commit(kinds[k], 1'b0, vals[v]);
                vectors++; if (pc !== want[k*3+v]) begin
                    errors++; $display("FAIL sign_br k=%0d rs=%h got %h want %h", k, vals[v], pc, want[k*3+v]);
                end
                exp_pc = want[k*3+v];
            end
        end
    endtask

    task automatic test_jal_jr();
        int rc; bit st, ok; logic [31:0] a;
        goto_pc(32'h4000_0100);
        serve(W_JAL, 0, rc, st, a, ok);
        vectors++; if (link_addr !== 32'h4000_0104) begin
            errors++; $display("FAIL jal_link got %h want 40000104", link_addr);
        end
        commit(C_JUMP, 1'b0, 32'h0);
        vectors++; if (pc !== 32'h4000_0040) begin errors++; $display("FAIL jal_target got %h want 40000040", pc); end
        serve(W_JAL, 0, rc, st, a, ok);
        commit(C_JREG | C_JUMP, 1'b0, 32'h200);
        vectors++; if (pc !== 32'h200) begin errors++; $display("FAIL jr_override got %h want 00000200", pc); end
        exp_pc = 32'h200;
    endtask

    task automatic test_stall();
        int rc; bit st, ok; logic [31:0] a;
        serve(W_ADD, 0, rc, st, a, ok);
        stall = 1'b1; ctl = C_JUMP;
        for (int i = 0; i < 5; i++) begin
            tick();
            vectors++; if (bus.imem_req !== 1'b0 || pc !== exp_pc || instr_valid !== 1'b1 || instr !== W_ADD) begin
                errors++; $display("FAIL stall_hold cyc=%0d got req=%b pc=%h v=%b want pc=%h", i, bus.imem_req, pc, instr_valid, exp_pc);
            end
        end
        commit(C_NONE, 1'b0, 32'h0);
        exp_pc = exp_pc + 32'd4;
        vectors++; if (pc !== exp_pc) begin errors++; $display("FAIL stall_release got %h want %h", pc, exp_pc); end
    endtask

    task automatic test_reset_mid_wait();
        bus.imem_ready = 1'b0;
        tick(); tick();
        vectors++; if (bus.imem_req !== 1'b1) begin errors++; $display("FAIL wait_before_rst got req=%b want 1", bus.imem_req); end
        rst = 1'b1;
        #1;
        vectors++; if (bus.imem_req !== 1'b0 || pc !== 32'h0) begin
            errors++; $display("FAIL rst_abort got req=%b pc=%h want 0/00000000", bus.imem_req, pc);
        end
        tick();
        rst = 1'b0;
        tick();
        exp_pc = 32'h0;
        vectors++; if (bus.imem_req !== 1'b1 || bus.imem_addr !== 32'h0) begin
            errors++; $display("FAIL rst_restart got req=%b addr=%h", bus.imem_req, bus.imem_addr);
        end
    endtask

    task automatic test_random();
        int rc; bit st, ok; logic [31:0] a;
        logic [31:0] word, rs;
        logic [6:0]  c;
        logic        az;
        int          dly, kind, stalls;
        for (int it = 0; it < 40; it++) begin
            word   = $urandom;
            dly    = $urandom_range(0, 3);
            kind   = $urandom_range(0, 8);
            stalls = $urandom_range(0, 2);
            az     = 1'($urandom_range(0, 1));
            case ($urandom_range(0, 3))
                0: rs = 32'h0;
                1: rs = 32'h8000_0000;
                default: rs = $urandom;
            endcase
            case (kind)
                0: c = C_NONE;
                1: c = C_JREG;
                2: c = C_JUMP;
                3: c = C_BEQ;
                4: c = C_BNE;
                5: c = C_BGTZ;
                6: c = C_BGEZ;
                7: c = C_BLTZ;
                default: c = 7'($urandom);
            endcase
`ifdef FETCH_MISALIGN_CHECK_EN
            rs = rs & 32'hFFFF_FFFC;
`endif
            serve(word, dly, rc, st, a, ok);
            vectors++; if (!ok || a !== exp_pc || rc != dly + 1 || !st) begin
                errors++; $display("FAIL rnd_fetch it=%0d got addr=%h cnt=%0d st=%0d want addr=%h cnt=%0d", it, a, rc, st, exp_pc, dly + 1);
            end
            vectors++; if (instr !== word || link_addr !== exp_pc + 32'd4) begin
                errors++; $display("FAIL rnd_hold it=%0d got instr=%h link=%h want %h/%h", it, instr, link_addr, word, exp_pc + 32'd4);
            end
            stall = 1'b1;
            for (int s = 0; s < stalls; s++) tick();
            commit(c, az, rs);
            exp_pc = model_next(exp_pc, word, c, az, rs);
            vectors++; if (pc !== exp_pc) begin
                errors++; $display("FAIL rnd_pc it=%0d ctl=%b got %h want %h", it, c, pc, exp_pc);
            end
        end
    endtask

    initial begin
        test_reset();
        test_sequential();
        test_wait_latency();
        test_beq();
        test_sign_branches();
        test_jal_jr();
        test_stall();
        test_reset_mid_wait();
        test_random();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
        $finish;
    end

endmodule
